ste_peak_meter: RTL and testbench
=================================

Name: ste_peak_meter

Overview:
- Upstream stage of the LED bar-graph driver.
- Takes signed ADC samples with a valid strobe and finds the maximum magnitude over a fixed window of samples.
- At the end of each window it emits a DOUT_W-bit level with a one-cycle update pulse.
- Also drives a peak-hold level with hold time and linear decay, so the bar graph can show a falling peak marker.

Parameters:
- DIN_W, 12: width of the signed two's-complement input sample.
- DOUT_W, 4: width of the level outputs; must satisfy DOUT_W <= DIN_W-1.
- WIN_LEN, 1024: number of valid samples per window; must be >= 2.
- HOLD_WIN, 4: number of windows the held peak stays frozen before decay starts.
- DECAY_STEP, 1: amount (in DOUT_W LSBs) the held peak drops per window while decaying.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- din_i  in  DIN_W  signed input sample.
- din_valid_i  in  1  sample strobe; one sample is accepted per cycle while high.
- clr_i  in  1  synchronous clear of all state.
- dout_o  out  DOUT_W  window peak level.
- dout_update_o  out  1  one-cycle pulse; dout_o is new in this cycle.
- peak_o  out  DOUT_W  held/decaying peak level; changes only together with dout_update_o.

Behaviour:
- Reset and clear:
  - On rst or clr_i, all outputs become 0, the pipeline is flushed, and the sample and hold counters are zeroed.
  - A sample presented in the same cycle as rst or clr_i is dropped.
  - rst and clr_i have identical effect.
- Stage 1 (registered): magnitude = |din_i|. The most negative value -2^(DIN_W-1) saturates to 2^(DIN_W-1)-1.
- Stage 2 (registered): window running max.
  - The first sample of a window loads the max register directly, with no compare against the old value.
  - Later samples load it only if their magnitude > the current max.
- Sample counter:
  - Width clog2(WIN_LEN); counts stage-1 valid samples.
  - Wraps from WIN_LEN-1 to 0.
  - A window-done flag travels with the last sample.
- Latency: dout_update_o rises exactly 2 cycles after the clock edge at which the WIN_LEN-th valid sample is accepted.
- Scaling: dout_o = max[DIN_W-2 -: DOUT_W], i.e. truncation to the top DOUT_W bits of the magnitude.
- Back-to-back operation:
  - Samples keep being accepted in the update cycle and every other cycle; there are no stall or ready signals.
  - The next window starts with the sample after the last one, with no loss.
- Invalid cycles: din_valid_i low advances nothing; gaps of any length are allowed.
- Hold FSM, states HOLD and DECAY, evaluated once per window-done with new window level L and held value P:
  - If L >= P: P <= L, hold counter <= HOLD_WIN, state <= HOLD.
  - In HOLD with L < P: decrement the hold counter. When it reaches 0, go to DECAY (P is unchanged in that window).
  - In DECAY with L < P: P <= max(P - DECAY_STEP, L). Saturating arithmetic; P never goes below L.
  - HOLD_WIN = 0 means decay starts in the first window where L < P.
- peak_o is registered and updates in the same cycle as dout_update_o.
- Reset state: P = 0, state HOLD, hold counter = 0.

Optional Feature:
- Macro: STE_PEAK_METER_HOLD_EN.
- Defined: hold counter, HOLD/DECAY FSM and peak_o behave as specified above.
- Undefined:
  - Hold logic is not synthesised.
  - peak_o equals dout_o with identical timing.
  - HOLD_WIN and DECAY_STEP are ignored.

Decomposition:
- Package ste_meter_pkg holds:
  - typedef enum hold_state_e {HOLD, DECAY};
  - a function for the saturating magnitude;
  - a function for saturating subtract-with-floor.
- One sub-module, ste_peak_hold: the hold/decay FSM. It takes the level plus the update pulse and produces peak_o.
- ste_peak_meter contains the magnitude/window pipeline and instantiates ste_peak_hold under the macro.

Test Plan (DIN_W=12, DOUT_W=4, WIN_LEN=8, HOLD_WIN=2, DECAY_STEP=1, macro defined):
- 8 consecutive valid samples {0,100,-1024,50,7,-3,900,1} -> single dout_update_o pulse 2 cycles after the 8th sample, dout_o=8, peak_o=8.
- Window with samples {-2048, 0 x7} -> dout_o=15 (saturated magnitude); window of all 2047 -> 15; window of all 127 -> 0; window of all 128 -> 1.
- Window peaks 15, then continuous windows of 2 -> peak_o sequence: 15, 15, 15, 14, 13, ..., 3, 2, 2 (never below 2); dout_o=2 in every later window.
- Samples valid every 3rd cycle -> update only after 8 valid samples (24 cycles); pulse gap between windows = 24 cycles; values are the same as the dense case.
- clr_i asserted after 5 samples of a window holding magnitude 2047 -> no pulse, outputs 0; the next 8 samples of magnitude 256 -> dout_o=2, peak_o=2.
- rst asserted in the cycle after the last sample of a window -> no dout_update_o pulse; all outputs 0; peak state reset (next window of 512 -> peak_o=4).

Source files
------------

// File: rtl/ste_peak_meter_pkg.sv
// Shared types and arithmetic helpers for the peak meter and its hold stage.
package ste_meter_pkg;

  typedef enum logic {HOLD, DECAY} hold_state_e;

  // |x| clamped to the largest positive value of a w-bit signed number.
  function automatic logic [31:0] sat_mag(input logic signed [31:0] x, input int unsigned w);
    logic [31:0] lim;
    logic [31:0] ax;
    lim = (32'd1 << (w - 1)) - 32'd1;
    ax  = x[31] ? (~x + 32'd1) : x;
    return (ax > lim) ? lim : ax;
  endfunction

  // p - step, never below zero and never below floor.
  function automatic logic [31:0] sub_floor(input logic [31:0] p, input logic [31:0] step,
                                            input logic [31:0] floor);
    logic [31:0] d;
    d = (p > step) ? (p - step) : 32'd0;
    return (d < floor) ? floor : d;
  endfunction

endpackage

// File: rtl/ste_peak_meter_if.sv
// Sample-in / level-out bundle of the peak meter; slave is the meter side.
interface ste_peak_meter_if #(
  parameter int DIN_W  = 12,
  parameter int DOUT_W = 4
);
  logic signed [DIN_W-1:0]  din_i;
  logic                     din_valid_i;
  logic                     clr_i;
  logic        [DOUT_W-1:0] dout_o;
  logic                     dout_update_o;
  logic        [DOUT_W-1:0] peak_o;

  modport master (
    output din_i, din_valid_i, clr_i,
    input  dout_o, dout_update_o, peak_o
  );

  modport slave (
    input  din_i, din_valid_i, clr_i,
    output dout_o, dout_update_o, peak_o
  );
endinterface

// File: rtl/ste_peak_meter_peak_hold.sv
// Held peak: freezes for HOLD_WIN windows after a new peak, then falls by DECAY_STEP
// per window, never below the current window level; evaluated once per update pulse.
module ste_peak_hold
  import ste_meter_pkg::*;
#(
  parameter int DOUT_W     = 4,
  parameter int HOLD_WIN   = 4,
  parameter int DECAY_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DOUT_W-1:0] level,
  input  logic              upd,
  output logic [DOUT_W-1:0] peak
);

  localparam int HW_W = (HOLD_WIN > 0) ? $clog2(HOLD_WIN + 1) : 1;

  hold_state_e      state_q;
  logic [HW_W-1:0]  hcnt_q;
  logic [DOUT_W-1:0] peak_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= HOLD;
      hcnt_q  <= '0;
      peak_q  <= '0;
    end else if (upd) begin
      if (level >= peak_q) begin
        peak_q  <= level;
        hcnt_q  <= HW_W'(HOLD_WIN);
        state_q <= HOLD;
      end else if (state_q == HOLD && hcnt_q != '0) begin
        // last hold window leaves the peak untouched; decay starts next window
        hcnt_q <= hcnt_q - HW_W'(1);
        if (hcnt_q == HW_W'(1)) state_q <= DECAY;
      end else begin
        peak_q  <= DOUT_W'(sub_floor(32'(peak_q), 32'(DECAY_STEP), 32'(level)));
        state_q <= DECAY;
      end
    end
  end

  assign peak = peak_q;

endmodule

// File: rtl/ste_peak_meter.sv
// Window peak meter: |sample| -> window max -> DOUT_W-bit level, update pulse 2 cycles
// after the last sample; no backpressure. Hold/decay peak enabled by STE_PEAK_METER_HOLD_EN.
module ste_peak_meter
  import ste_meter_pkg::*;
#(
  parameter int DIN_W      = 12,
  parameter int DOUT_W     = 4,
  parameter int WIN_LEN    = 1024,
  parameter int HOLD_WIN   = 4,
  parameter int DECAY_STEP = 1
) (
  input logic              clk,
  input logic              rst,
  ste_peak_meter_if.slave  bus
);

  localparam int CNT_W = $clog2(WIN_LEN);

  if (DOUT_W > DIN_W - 1 || WIN_LEN < 2 || HOLD_WIN < 0 || DECAY_STEP < 0) begin : g_bad_cfg
    $error("ste_peak_meter: illegal parameter set");
  end

  logic              flush;
  logic [DIN_W-1:0]  mag_q;
  logic              s1_vld_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DIN_W-1:0]  max_q;
  logic              done_q;
  logic [DOUT_W-1:0] level;
  logic [DOUT_W-1:0] dout_q;
  logic              upd_q;

  assign flush = rst | bus.clr_i;
  assign level = max_q[DIN_W-2 -: DOUT_W];

  always_ff @(posedge clk) begin
    if (flush) begin
      mag_q    <= '0;
      s1_vld_q <= 1'b0;
      cnt_q    <= '0;
      max_q    <= '0;
      done_q   <= 1'b0;
      dout_q   <= '0;
      upd_q    <= 1'b0;
    end else begin
      s1_vld_q <= bus.din_valid_i;
      if (bus.din_valid_i) mag_q <= DIN_W'(sat_mag(32'(bus.din_i), DIN_W));

      done_q <= 1'b0;
      if (s1_vld_q) begin
        // first sample of a window overwrites whatever the previous window left
        if (cnt_q == '0 || mag_q > max_q) max_q <= mag_q;
        done_q <= (cnt_q == CNT_W'(WIN_LEN - 1));
        cnt_q  <= (cnt_q == CNT_W'(WIN_LEN - 1)) ? '0 : cnt_q + CNT_W'(1);
      end

      upd_q <= done_q;
      if (done_q) dout_q <= level;
    end
  end

  assign bus.dout_o        = dout_q;
  assign bus.dout_update_o = upd_q;

`ifdef STE_PEAK_METER_HOLD_EN
  ste_peak_hold #(
    .DOUT_W    (DOUT_W),
    .HOLD_WIN  (HOLD_WIN),
    .DECAY_STEP(DECAY_STEP)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.clr_i),
    .level(level),
    .upd  (done_q),
    .peak (bus.peak_o)
  );
`else
  assign bus.peak_o = dout_q;
`endif

endmodule

// File: tb/tb_ste_peak_meter.sv
// Directed bench for ste_peak_meter with WIN_LEN=8, HOLD_WIN=2, DECAY_STEP=1.
module tb_ste_peak_meter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ste_peak_meter_if #(.DIN_W(12), .DOUT_W(4)) bus ();

  ste_peak_meter #(
    .DIN_W(12), .DOUT_W(4), .WIN_LEN(8), .HOLD_WIN(2), .DECAY_STEP(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;
  int q_dout[$];
  int q_peak[$];
  int q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.dout_update_o) begin
      q_dout.push_back(int'(bus.dout_o));
      q_peak.push_back(int'(bus.peak_o));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // expected peak_o: held value with the hold feature, else it mirrors dout_o
  function automatic int pk(input int hold_v, input int d);
`ifdef STE_PEAK_METER_HOLD_EN
    return hold_v;
`else
    return d;
`endif
  endfunction

  task automatic put(input int v, input int gap);
    bus.din_i = 12'(v);
    bus.din_valid_i = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
    bus.din_valid_i = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic win8(input int a[8], input int gap);
    for (int i = 0; i < 8; i++) put(a[i], gap);
  endtask

  task automatic win_const(input int v, input int gap);
    for (int i = 0; i < 8; i++) put(v, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_win(input string tag, input int ed, input int ep);
    int n;
    int c;
    n = 0;
    while (q_dout.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q_dout.size() == 0) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    c = q_cyc.pop_front();
    chk({tag, "_dout"}, q_dout.pop_front(), ed);
    chk({tag, "_peak"}, q_peak.pop_front(), ep);
    chk({tag, "_lat"}, c - last_acc, 2);
  endtask

  int v1[8] = '{0, 100, -1024, 50, 7, -3, 900, 1};
  int v2[8] = '{-2048, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    int ep;
    rst = 1'b1;
    bus.din_i = '0;
    bus.din_valid_i = 1'b0;
    bus.clr_i = 1'b0;
    idle(3);
    chk("rst_dout", int'(bus.dout_o), 0);
    chk("rst_peak", int'(bus.peak_o), 0);
    chk("rst_upd", int'(bus.dout_update_o), 0);
    rst = 1'b0;
    idle(2);

    win8(v1, 1);              expect_win("mixed", 8, pk(8, 8));
    win8(v2, 1);              expect_win("neg_full", 15, pk(15, 15));
    win_const(2047, 1);       expect_win("pos_full", 15, pk(15, 15));
    win_const(127, 1);        expect_win("below_lsb", 0, pk(15, 0));
    win_const(128, 1);        expect_win("one_lsb", 1, pk(15, 1));

    // one full-scale window, then 16 back-to-back windows at level 2
    win_const(2047, 1);
    for (int k = 0; k < 16; k++) win_const(256, 1);
    idle(6);
    chk("decay_count", q_dout.size(), 17);
    if (q_dout.size() == 17) begin
      void'(q_cyc.pop_front());
      chk("decay_top_dout", q_dout.pop_front(), 15);
      chk("decay_top_peak", q_peak.pop_front(), pk(15, 15));
      for (int k = 1; k <= 16; k++) begin
        ep = (k <= 2) ? 15 : ((17 - k > 2) ? 17 - k : 2);
        void'(q_cyc.pop_front());
        chk($sformatf("decay%0d_dout", k), q_dout.pop_front(), 2);
        chk($sformatf("decay%0d_peak", k), q_peak.pop_front(), pk(ep, 2));
      end
    end
    q_dout.delete(); q_peak.delete(); q_cyc.delete();

    // sparse input: one valid sample every 3rd cycle
    win8(v1, 3);
    win8(v1, 3);
    idle(6);
    chk("sparse_count", q_dout.size(), 2);
    if (q_dout.size() == 2) begin
      c0 = q_cyc.pop_front();
      c1 = q_cyc.pop_front();
      chk("sparse_gap", c1 - c0, 24);
      chk("sparse_lat", c1 - last_acc, 2);
      chk("sparse0_dout", q_dout.pop_front(), 8);
      chk("sparse0_peak", q_peak.pop_front(), pk(8, 8));
      chk("sparse1_dout", q_dout.pop_front(), 8);
      chk("sparse1_peak", q_peak.pop_front(), pk(8, 8));
    end
    q_dout.delete(); q_peak.delete(); q_cyc.delete();

    // clear part-way through a full-scale window
    for (int i = 0; i < 5; i++) put(2047, 1);
    bus.clr_i = 1'b1;
    idle(1);
    bus.clr_i = 1'b0;
    idle(6);
    chk("clr_no_pulse", q_dout.size(), 0);
    chk("clr_dout", int'(bus.dout_o), 0);
    chk("clr_peak", int'(bus.peak_o), 0);
    q_dout.delete(); q_peak.delete(); q_cyc.delete();
    win_const(256, 1);        expect_win("after_clr", 2, pk(2, 2));

    // reset in the cycle after a window's last sample
    win_const(2047, 1);       expect_win("pre_rst", 15, pk(15, 15));
    win_const(2047, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(6);
    chk("rst_no_pulse", q_dout.size(), 0);
    chk("rst2_dout", int'(bus.dout_o), 0);
    chk("rst2_peak", int'(bus.peak_o), 0);
    q_dout.delete(); q_peak.delete(); q_cyc.delete();
    win_const(512, 1);        expect_win("after_rst", 4, pk(4, 4));

    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
